bsg_arb_round_robin_lock: RTL
=============================

// Module: bsg_arb_round_robin_lock
// PURPOSE
//  Round-robin arbiter for a shared single-beat or multi-beat resource (e.g. an output channel).
//  Grants one of inputs_p requesters per cycle with rotating priority.
//  Holds the grant across multi-beat transactions until the final beat is consumed.
//  Sits between requester FIFOs and the shared channel. Pairs with a fixed-priority encoder
//  for the per-cycle pick.
// PARAMETERS
//  inputs_p    16   number of requesters, >=2
//  lg_inputs_p $clog2(inputs_p)   width of grant_id_o (derived localparam, not overridable)
// PORTS
//  clk_i       in   1            clock
//  reset_i     in   1            synchronous, active-high reset
//  reqs_i      in   inputs_p     per-requester request, level
//  last_i      in   1            qualifies the current beat as the final beat of the granted transaction
//  yumi_i      in   1            consumer accepts the current beat; legal only when v_o=1
//  v_o         out  1            a grant is valid this cycle
//  grants_o    out  inputs_p     one-hot grant, all zero when v_o=0
//  grant_id_o  out  lg_inputs_p  binary index of the granted requester; 0 when v_o=0
//  locked_o    out  1            arbiter is holding a grant mid-transaction
// BEHAVIOUR
//  - Grant is combinational from reqs_i and state: zero-cycle latency. State updates on posedge clk_i only.
//  - Reset (reset_i=1): ptr_r=0, state=UNLOCKED, locked_id_r=0. v_o, grants_o, grant_id_o and locked_o
//    are forced to 0 while reset_i=1, regardless of reqs_i.
//  - Priority: ptr_r is the highest-priority index. Priority decreases ptr_r, ptr_r+1, ..., wrapping mod inputs_p.
//  - UNLOCKED: grant the first asserted req at or after ptr_r. v_o = |reqs_i.
//    - On v_o & yumi_i & last_i: ptr_r <= (grant_id+1) mod inputs_p; stay UNLOCKED.
//    - On v_o & yumi_i & ~last_i: locked_id_r <= grant_id; go to LOCKED. ptr_r is unchanged.
//    - On ~yumi_i: no state change. The grant may change next cycle if reqs_i changes.
//  - LOCKED: grants_o = onehot(locked_id_r) & reqs_i. Other requests are ignored.
//    - v_o = reqs_i[locked_id_r]. A dropped request gives v_o=0 and the lock is held.
//    - locked_o = 1.
//    - On v_o & yumi_i & last_i: ptr_r <= (locked_id_r+1) mod inputs_p; go to UNLOCKED.
//    - On v_o & yumi_i & ~last_i: stay LOCKED.
//  - Wrap: grant_id = inputs_p-1 with last accepted gives ptr_r = 0.
//  - yumi_i while v_o=0 is a protocol error: assertion fires; state must not change.
//  - Reset mid-transaction: lock is dropped; next cycle behaves as a fresh UNLOCKED with ptr_r=0.
//  - Fairness: with all requesters continuously asserting single-beat transactions, each requester is
//    granted exactly once every inputs_p accepted beats.
// STRUCTURE
//  - Shared package bsg_arb_pkg: state enum bsg_arb_lock_state_e {e_unlocked, e_locked}.
//  - Sub-module: bsg_priority_encode_one_hot_out (lo_to_hi_p=1), instantiated twice:
//    - on reqs_i masked to indices >= ptr_r;
//    - on unmasked reqs_i.
//    Use the masked result if it is nonzero, else the unmasked result (standard two-encoder round robin).
//  - One-hot to binary for grant_id_o via bsg_encode_one_hot.
//  - Registers: ptr_r, locked_id_r, state_r. No other storage.
// TESTING
//  (inputs_p=4 unless noted)
//  1. Reset held with reqs_i=4'b1111 -> v_o=0, grants_o=0, locked_o=0.
//     After release -> grants_o=4'b0001.
//  2. reqs_i=4'b1111, yumi_i=1, last_i=1 for 8 cycles -> grants_o sequence
//     0001,0010,0100,1000,0001,0010,0100,1000.
//  3. Requester 1 sends a 3-beat transaction while reqs_i=4'b1111 (last_i on the 3rd beat)
//     -> grants_o=0010 for 3 accepted beats, locked_o=1 after beat 1,
//     next grant is 0100 (ptr_r=2).
//  4. LOCKED on id 2, reqs_i drops to 4'b1011 for 2 cycles -> v_o=0, grants_o=0, locked_o=1.
//     reqs_i returns -> grants_o=0100 resumes.
//  5. ptr_r=3, reqs_i=4'b0110, single-beat accepts -> grants 0010 then 0100 (wrap-around search).
//  6. inputs_p=16, locked on id 15, reset_i pulsed one cycle
//     -> locked_o=0 and next grant is the lowest asserted index.

Source files
------------

// File: rtl/bsg_arb_pkg.sv
// Shared types for the bsg round-robin lock arbiter.
// Holds the lock FSM state encoding.
package bsg_arb_pkg;

  typedef enum logic {
    e_unlocked = 1'b0,
    e_locked   = 1'b1
  } bsg_arb_lock_state_e;

endpackage

// File: rtl/bsg_encode_one_hot.sv
// One-hot to binary index; combinational, no backpressure.
// An all-zero input yields index 0.
module bsg_encode_one_hot #(
  parameter  int width_p      = 16,
  localparam int addr_width_p = $clog2(width_p)
) (
  input  logic [width_p-1:0]      i,
  output logic [addr_width_p-1:0] addr_o
);

  always_comb begin
    addr_o = '0;
    for (int j = 0; j < width_p; j++) begin
      if (i[j]) addr_o = addr_o | addr_width_p'(j);
    end
  end

endmodule

// File: rtl/bsg_priority_encode_one_hot_out.sv
// Fixed-priority pick, one-hot out; combinational, no backpressure.
// lo_to_hi_p=1 gives index 0 the highest priority.
module bsg_priority_encode_one_hot_out #(
  parameter int width_p    = 16,
  parameter bit lo_to_hi_p = 1'b1
) (
  input  logic [width_p-1:0] i,
  output logic [width_p-1:0] o,
  output logic               v_o
);

  logic found;

  always_comb begin
    o     = '0;
    found = 1'b0;
    for (int j = 0; j < width_p; j++) begin
      if (!found && i[lo_to_hi_p ? j : width_p-1-j]) begin
        o[lo_to_hi_p ? j : width_p-1-j] = 1'b1;
        found = 1'b1;
      end
    end
  end

  assign v_o = |i;

endmodule

// File: rtl/bsg_arb_round_robin_lock.sv
// Round-robin arbiter with a grant lock held across multi-beat transactions.
// Grant is combinational (zero latency); state advances only on an accepted beat (v_o & yumi_i).
module bsg_arb_round_robin_lock
  import bsg_arb_pkg::*;
#(
  parameter  int inputs_p    = 16,
  localparam int lg_inputs_p = $clog2(inputs_p)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [inputs_p-1:0]    reqs_i,
  input  logic                   last_i,
  input  logic                   yumi_i,
  output logic                   v_o,
  output logic [inputs_p-1:0]    grants_o,
  output logic [lg_inputs_p-1:0] grant_id_o,
  output logic                   locked_o
);

  logic [lg_inputs_p-1:0] ptr_r;
  logic [lg_inputs_p-1:0] locked_id_r;
  bsg_arb_lock_state_e    state_r;

  logic [inputs_p-1:0]    mask;
  logic [inputs_p-1:0]    masked_oh, unmasked_oh;
  logic                   masked_v, unmasked_v;
  logic [inputs_p-1:0]    unlocked_grant, locked_grant;
  logic [lg_inputs_p-1:0] next_ptr;
  logic                   accept;

  always_comb begin
    mask = '0;
    for (int j = 0; j < inputs_p; j++) begin
      mask[j] = (lg_inputs_p'(j) >= ptr_r);
    end
  end

  bsg_priority_encode_one_hot_out #(.width_p(inputs_p), .lo_to_hi_p(1'b1)) pe_masked (
    .i   (reqs_i & mask),
    .o   (masked_oh),
    .v_o (masked_v)
  );

  bsg_priority_encode_one_hot_out #(.width_p(inputs_p), .lo_to_hi_p(1'b1)) pe_unmasked (
    .i   (reqs_i),
    .o   (unmasked_oh),
    .v_o (unmasked_v)
  );

  // Nothing at or above ptr_r means the search wraps to the lowest index.
  assign unlocked_grant = masked_v ? masked_oh : unmasked_oh;
  assign locked_grant   = (inputs_p'(1) << locked_id_r) & reqs_i;

  always_comb begin
    grants_o = '0;
    v_o      = 1'b0;
    locked_o = 1'b0;
    if (!reset_i) begin
      if (state_r == e_locked) begin
        grants_o = locked_grant;
        v_o      = reqs_i[locked_id_r];
        locked_o = 1'b1;
      end else begin
        grants_o = unlocked_grant;
        v_o      = unmasked_v;
      end
    end
  end

  bsg_encode_one_hot #(.width_p(inputs_p)) enc (
    .i      (grants_o),
    .addr_o (grant_id_o)
  );

  assign next_ptr = (grant_id_o == lg_inputs_p'(inputs_p-1)) ? '0 : grant_id_o + 1'b1;
  assign accept   = v_o & yumi_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_r       <= '0;
      locked_id_r <= '0;
      state_r     <= e_unlocked;
    end else if (accept) begin
      if (last_i) begin
        ptr_r   <= next_ptr;
        state_r <= e_unlocked;
      end else begin
        locked_id_r <= grant_id_o;
        state_r     <= e_locked;
      end
    end
  end

  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

endmodule
